// File: rtl/regfile_rd_if.sv
// regfile_rd_if: write port, read request and registered read results of the register file.
interface regfile_rd_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic              RegWrite;
    logic [ADDR_W-1:0] waddr;
    logic [DATA_W-1:0] idat;
    logic              ReadEn;
    logic [ADDR_W-1:0] raddr_a;
    logic [ADDR_W-1:0] raddr_b;
    logic [DATA_W-1:0] odat_a;
    logic [DATA_W-1:0] odat_b;
    logic              ovalid;
    modport master (
        output RegWrite, waddr, idat, ReadEn, raddr_a, raddr_b,
        input  odat_a, odat_b, ovalid
    );
    modport slave (
        input  RegWrite, waddr, idat, ReadEn, raddr_a, raddr_b,
        output odat_a, odat_b, ovalid
    );
endinterface

// File: rtl/regfile_rd.sv
// regfile_rd: 2-read/1-write register file, r0 hard-wired zero, registered reads with write forwarding.
module regfile_rd #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input logic         clk,
    input logic         rst_n,
    regfile_rd_if.slave bus
);
    localparam int DEPTH = 1 << ADDR_W;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rd_a;
    logic [DATA_W-1:0] rd_b;
    // A same-cycle write to the addressed register bypasses storage so operands are never stale.
    always_comb begin
        rd_a = bus.raddr_a == '0 ? '0 :
               (bus.RegWrite && bus.waddr == bus.raddr_a) ? bus.idat : mem[bus.raddr_a];
        rd_b = bus.raddr_b == '0 ? '0 :
               (bus.RegWrite && bus.waddr == bus.raddr_b) ? bus.idat : mem[bus.raddr_b];
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (bus.RegWrite && bus.waddr != '0) begin
            mem[bus.waddr] <= bus.idat;
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.odat_a <= '0;
            bus.odat_b <= '0;
            bus.ovalid <= 1'b0;
        end else begin
            bus.ovalid <= bus.ReadEn;
            if (bus.ReadEn) begin
                bus.odat_a <= rd_a;
                bus.odat_b <= rd_b;
            end
        end
    end
endmodule

// File: tb/tb_regfile_rd.sv
// tb_regfile_rd: directed stimulus feeding an expected-result queue; a negedge monitor checks DUT results.
module tb_regfile_rd;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    logic exp_v;
    logic [63:0] sb_q[$];
    regfile_rd_if #(.DATA_W(32), .ADDR_W(5)) bus ();
    regfile_rd #(.DATA_W(32), .ADDR_W(5)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    always #5 clk = ~clk;
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask
    // ovalid must follow the ReadEn this bench drove at the previous edge.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) exp_v <= 1'b0;
        else exp_v <= bus.ReadEn;
    end
    always @(negedge clk) begin
        if (rst_n) begin
            check("ovalid", {31'b0, bus.ovalid}, {31'b0, exp_v});
            if (bus.ovalid) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_empty: got ovalid=1 expected no pending read");
                end else begin
                    logic [63:0] e;
                    e = sb_q.pop_front();
                    check("odat_a", bus.odat_a, e[63:32]);
                    check("odat_b", bus.odat_b, e[31:0]);
                end
            end
        end
    end
    task automatic step(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                        input logic re, input logic [4:0] ra, input logic [4:0] rb,
                        input logic [31:0] ea, input logic [31:0] eb);
        bus.RegWrite = we;
        bus.waddr    = wa;
        bus.idat     = wd;
        bus.ReadEn   = re;
        bus.raddr_a  = ra;
        bus.raddr_b  = rb;
        if (re && rst_n) sb_q.push_back({ea, eb});
        @(posedge clk);
        #1;
    endtask
    initial begin
        bus.RegWrite = 1'b0;
        bus.waddr    = '0;
        bus.idat     = '0;
        bus.ReadEn   = 1'b0;
        bus.raddr_a  = '0;
        bus.raddr_b  = '0;
        #12;
        check("rst_odat_a", bus.odat_a, 32'h0);
        check("rst_odat_b", bus.odat_b, 32'h0);
        check("rst_ovalid", {31'b0, bus.ovalid}, 32'h0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        // write/read
        step(1, 5, 32'hDEADBEEF, 0, 0, 0, 0, 0);
        step(1, 9, 32'h12345678, 0, 0, 0, 0, 0);
        step(0, 0, 0, 1, 5, 9, 32'hDEADBEEF, 32'h12345678);
        step(0, 0, 0, 0, 0, 0, 0, 0);
        // zero register
        step(1, 0, 32'hFFFFFFFF, 1, 0, 0, 32'h0, 32'h0);
        step(0, 0, 0, 1, 0, 5, 32'h0, 32'hDEADBEEF);
        // forwarding on both ports, then storage holds the forwarded value
        step(1, 7, 32'h1, 0, 0, 0, 0, 0);
        step(1, 7, 32'hA5A5A5A5, 1, 7, 7, 32'hA5A5A5A5, 32'hA5A5A5A5);
        step(1, 9, 32'h99, 1, 7, 9, 32'hA5A5A5A5, 32'h99);
        // hold
        step(1, 3, 32'h33, 0, 0, 0, 0, 0);
        step(0, 0, 0, 1, 3, 0, 32'h33, 32'h0);
        step(1, 3, 32'h44, 0, 0, 0, 0, 0);
        check("hold_a0", bus.odat_a, 32'h33);
        step(0, 0, 0, 0, 0, 0, 0, 0);
        check("hold_a1", bus.odat_a, 32'h33);
        step(0, 0, 0, 0, 0, 0, 0, 0);
        check("hold_a2", bus.odat_a, 32'h33);
        step(0, 0, 0, 1, 3, 3, 32'h44, 32'h44);
        // streaming sweep over preloaded data
        for (int i = 1; i < 32; i++) step(1, 5'(i), 32'(i) * 32'h01010101, 0, 0, 0, 0, 0);
        for (int i = 0; i < 32; i++)
            step(0, 0, 0, 1, 5'(i), 5'(31 - i), 32'(i) * 32'h01010101, 32'(31 - i) * 32'h01010101);
        // asynchronous reset mid-operation while a result is on the outputs
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("arst_odat_a", bus.odat_a, 32'h0);
        check("arst_ovalid", {31'b0, bus.ovalid}, 32'h0);
        bus.RegWrite = 1'b1;
        bus.waddr    = 5'd6;
        bus.idat     = 32'hCAFEF00D;
        bus.ReadEn   = 1'b1;
        bus.raddr_a  = 5'd6;
        bus.raddr_b  = 5'd31;
        @(posedge clk);
        #2;
        check("arst_hold_a", bus.odat_a, 32'h0);
        check("arst_hold_b", bus.odat_b, 32'h0);
        check("arst_hold_v", {31'b0, bus.ovalid}, 32'h0);
        rst_n = 1'b1;
        #1;
        for (int i = 0; i < 32; i++) step(0, 0, 0, 1, 5'(i), 5'(31 - i), 32'h0, 32'h0);
        step(0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0);
        check("sb_drained", 32'(sb_q.size()), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
